// File: rtl/seg_display_arbiter_pkg.sv
// rtl/seg_display_arbiter_pkg.sv - shared widths, FSM states and one-hot helper for the display arbiter
package seg_disp_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int DISP_W     = DIGIT_W * NUM_DIGITS;
  localparam int MAX_REQ    = 8;
  localparam int IDX_W      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  // One-hot of a requester index, sized for the largest supported requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// rtl/seg_display_arbiter_if.sv - requester/display bundle between application logic and the arbiter
interface seg_display_arbiter_if
  import seg_disp_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DISP_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [IDX_W-1:0]          owner_idx;
  logic                      disp_valid;
  logic [DISP_W-1:0]         disp_data;

  // Application side: offers requests and words, observes the current owner.
  modport master (
    output req, req_data,
    input  grant, owner_idx, disp_valid, disp_data
  );

  // Arbiter side.
  modport slave (
    input  req, req_data,
    output grant, owner_idx, disp_valid, disp_data
  );

endinterface

// File: rtl/seg_display_arbiter_rr_pick.sv
// rtl/seg_display_arbiter_rr_pick.sv - combinational round-robin finder: first set request at or after start
module rr_pick
  import seg_disp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N-1:0] rot;
  int           s;

  // Rotate so that start_i lands on bit 0, then take the lowest set bit and map it back.
  always_comb begin
    rot     = N'({req_i, req_i} >> start_i);
    found_o = 1'b0;
    idx_o   = '0;
    s       = 0;
    for (int k = 0; k < N; k++) begin
      if (!found_o && rot[k]) begin
        found_o = 1'b1;
        s       = int'(start_i) + k;
        if (s >= N) s = s - N;
        idx_o   = IDX_W'(s);
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner of the 4-digit display with minimum dwell; SEG_ARB_HOLD_LAST_EN keeps the last word in IDLE
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int                NUM_REQ      = 4,
  parameter int                DWELL_CYCLES = 100000000,
  parameter logic [DISP_W-1:0] IDLE_WORD    = 16'h0000
) (
  input logic                  clk,
  input logic                  rst_n,
  seg_display_arbiter_if.slave bus
);

  localparam int               CNT_W    = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     owner_q;
  logic                 valid_q;
  logic [DISP_W-1:0]    data_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     last_q;

  logic [NUM_REQ-1:0]   own_mask;
  logic                 own_req;
  logic [NUM_REQ-1:0]   pick_req;
  logic [IDX_W-1:0]     start_idx;
  logic [DISP_W-1:0]    own_word;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [DISP_W-1:0]    pick_word;
  logic                 expired;
  logic                 take_new;
  logic                 go_idle;

  // Candidate set and scan origin; the owner is masked out so a hand-over never re-picks it,
  // and since last tracks every grant, last+1 is also owner+1 while showing.
  always_comb begin
    own_mask  = NUM_REQ'(onehot(owner_q));
    own_req   = |(bus.req & own_mask);
    pick_req  = (state_q == SHOW) ? (bus.req & ~own_mask) : bus.req;
    start_idx = (last_q == LAST_IDX) ? '0 : last_q + IDX_W'(1);
    own_word  = IDLE_WORD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) own_word = bus.req_data[DISP_W*i +: DISP_W];
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (pick_req),
    .start_i (start_idx),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Word of the requester about to be granted, loaded with the grant so it shows immediately.
  always_comb begin
    pick_word = IDLE_WORD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_word = bus.req_data[DISP_W*i +: DISP_W];
    end
  end

  // Decision for this cycle: new grant, fall back to IDLE, or keep the current owner.
  always_comb begin
    expired  = (cnt_q == CNT_MAX);
    take_new = pick_found && ((state_q == IDLE) || !own_req || expired);
    go_idle  = (state_q == SHOW) && !own_req && !pick_found;
  end

  // Arbitration FSM with all display outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      data_q  <= IDLE_WORD;
      cnt_q   <= '0;
      last_q  <= LAST_IDX;
    end else if (take_new) begin
      state_q <= SHOW;
      grant_q <= NUM_REQ'(onehot(pick_idx));
      owner_q <= pick_idx;
      valid_q <= 1'b1;
      data_q  <= pick_word;
      cnt_q   <= '0;
      last_q  <= pick_idx;
    end else if (go_idle) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SEG_ARB_HOLD_LAST_EN
      data_q  <= data_q;
`else
      data_q  <= IDLE_WORD;
`endif
    end else if (state_q == SHOW) begin
      data_q <= own_word;
      if (expired) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.grant      = grant_q;
  assign bus.owner_idx  = owner_q;
  assign bus.disp_valid = valid_q;
  assign bus.disp_data  = data_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed vector and sequence bench for seg_display_arbiter
module tb_seg_display_arbiter;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  seg_display_arbiter_if #(.NUM_REQ(4)) bus ();

  seg_display_arbiter #(
    .NUM_REQ      (4),
    .DWELL_CYCLES (8),
    .IDLE_WORD    (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  grant;
    logic [2:0]  owner;
    logic        valid;
    logic [15:0] disp;
  } vec_t;

  vec_t vecs [15];
  int   seq  [5];

  function automatic logic [15:0] idle_word(input logic [15:0] last_shown);
`ifdef SEG_ARB_HOLD_LAST_EN
    return last_shown;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [63:0] d);
    bus.req      = r;
    bus.req_data = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0000, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 64'h0);

    vecs[0]  = '{4'b0000, 64'h0000_0000_0000_0000, 4'b0000, 3'd0, 1'b0, 16'h0000};
    vecs[1]  = '{4'b0010, 64'h0000_0000_FACE_0000, 4'b0010, 3'd1, 1'b1, 16'hFACE};
    vecs[2]  = '{4'b0010, 64'h0000_0000_FACE_0000, 4'b0010, 3'd1, 1'b1, 16'hFACE};
    vecs[3]  = '{4'b0010, 64'h0000_0000_F00D_0000, 4'b0010, 3'd1, 1'b1, 16'hF00D};
    vecs[4]  = '{4'b0000, 64'h0000_0000_F00D_0000, 4'b0000, 3'd0, 1'b0, idle_word(16'hF00D)};
    vecs[5]  = '{4'b0000, 64'h0000_0000_0000_0000, 4'b0000, 3'd0, 1'b0, idle_word(16'hF00D)};
    vecs[6]  = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 3'd2, 1'b1, 16'h2222};
    vecs[7]  = '{4'b0101, 64'h0000_2222_0000_9999, 4'b0100, 3'd2, 1'b1, 16'h2222};
    vecs[8]  = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 3'd2, 1'b1, 16'h2222};
    vecs[9]  = '{4'b0001, 64'h0000_2222_0000_1111, 4'b0001, 3'd0, 1'b1, 16'h1111};
    vecs[10] = '{4'b0001, 64'h0000_2222_0000_1111, 4'b0001, 3'd0, 1'b1, 16'h1111};
    vecs[11] = '{4'b0000, 64'h0000_0000_0000_0000, 4'b0000, 3'd0, 1'b0, idle_word(16'h1111)};
    vecs[12] = '{4'b0100, 64'h0000_BEEF_0000_0000, 4'b0100, 3'd2, 1'b1, 16'hBEEF};
    vecs[13] = '{4'b0100, 64'h0000_BEEF_0000_0000, 4'b0100, 3'd2, 1'b1, 16'hBEEF};
    vecs[14] = '{4'b0000, 64'h0000_0000_0000_0000, 4'b0000, 3'd0, 1'b0, idle_word(16'hBEEF)};

    seq[0] = 0; seq[1] = 1; seq[2] = 3; seq[3] = 0; seq[4] = 1;

    // Idle after reset for 20 cycles.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("reset_grant", 64'(bus.grant), 64'h0);
      chk("reset_owner", 64'(bus.owner_idx), 64'h0);
      chk("reset_valid", 64'(bus.disp_valid), 64'h0);
      chk("reset_disp", 64'(bus.disp_data), 64'h0);
    end

    // Table of cycle-by-cycle vectors.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].req, vecs[i].data);
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), 64'(bus.grant), 64'(vecs[i].grant));
      chk($sformatf("vec%0d_owner", i), 64'(bus.owner_idx), 64'(vecs[i].owner));
      chk($sformatf("vec%0d_valid", i), 64'(bus.disp_valid), 64'(vecs[i].valid));
      chk($sformatf("vec%0d_disp", i), 64'(bus.disp_data), 64'(vecs[i].disp));
    end

    // Constant req=1011: owners 0,1,3,0,1 each for exactly 8 cycles.
    do_reset();
    drive(4'b1011, 64'hA003_0000_A001_A000);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_grant", c), 64'(bus.grant), 64'(4'b0001 << seq[c/8]));
      chk($sformatf("rr%0d_owner", c), 64'(bus.owner_idx), 64'(seq[c/8]));
      chk($sformatf("rr%0d_disp", c), 64'(bus.disp_data), 64'(16'hA000 | 16'(seq[c/8])));
    end

    // Sole requester 3 across several dwell expiries, with a word change mid-way.
    do_reset();
    drive(4'b1000, 64'h1234_0000_0000_0000);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk($sformatf("sole%0d_grant", c), 64'(bus.grant), 64'h8);
      chk($sformatf("sole%0d_valid", c), 64'(bus.disp_valid), 64'h1);
      chk($sformatf("sole%0d_disp", c), 64'(bus.disp_data), (c <= 15) ? 64'h1234 : 64'h5678);
      if (c == 15) drive(4'b1000, 64'h5678_0000_0000_0000);
    end

    // Asynchronous reset mid-dwell of owner 1, then restart from requester 0.
    do_reset();
    drive(4'b0010, 64'h0000_0000_ABCD_0000);
    repeat (4) @(negedge clk);
    chk("pre_rst_grant", 64'(bus.grant), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 64'(bus.grant), 64'h0);
    chk("arst_owner", 64'(bus.owner_idx), 64'h0);
    chk("arst_valid", 64'(bus.disp_valid), 64'h0);
    chk("arst_disp", 64'(bus.disp_data), 64'h0);
    drive(4'b0011, 64'h0000_0000_ABCD_7777);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 64'(bus.grant), 64'h1);
    chk("post_rst_owner", 64'(bus.owner_idx), 64'h0);
    chk("post_rst_disp", 64'(bus.disp_data), 64'h7777);

    // Reset while owner 0 holds; restart must again pick 0 rather than continue at 1.
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_valid", 64'(bus.disp_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst2_grant", 64'(bus.grant), 64'h1);
    chk("post_rst2_valid", 64'(bus.disp_valid), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
